clock_set_ctrl: RTL and testbench
=================================

# clock_set_ctrl

Mode/set controller for the hh:mm:ss timekeeping datapath. It owns the three counter stages (seconds, minutes, hours). In normal mode it sequences the stages: seconds advance on the 1 Hz enable, and each stage's carry advances the next. In set mode it takes button input to step one selected stage, with blink masks for the display, auto-repeat and an inactivity timeout. It sits between the button pins / prescaler and the counter stages.

## Interface
Parameters:
- REP_DLY, 2: en2hz ticks UP must be held before auto-repeat starts.
- TIMEOUT_S, 30: en1hz ticks without any button edge before set mode returns to normal.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-low reset.
- en1hz  in  1  one-cycle 1 Hz strobe from prescaler.
- en2hz  in  1  one-cycle 2 Hz strobe from prescaler.
- BTN_MODE, BTN_UP  in  1 each  raw button levels, active-high, asynchronous to CLK.
- CA_S, CA_M  in  1 each  carry outputs of the seconds and minutes stages (combinational, qualified by each stage's own strobe).
- INC_S, INC_M, INC_H  out  1 each  one-cycle step strobes to the seconds/minutes/hours stages. The stage EN inputs are tied high.
- CLR_S  out  1  synchronous clear of the seconds stage.
- SETTING  out  1  high whenever the controller is not in NORMAL.
- BLANK_S, BLANK_M, BLANK_H  out  1 each  display blank masks.

## Operation
- Buttons: each button has a 2-flop synchronizer and a rising-edge detector. The result is a one-cycle pulse, referred to below as mode_p / up_p.
- States: NORMAL, SET_H, SET_M, SET_S.
- Transitions on mode_p: NORMAL->SET_H->SET_M->SET_S->NORMAL.
- Timeout: in any SET_* state, the timeout counter reaching TIMEOUT_S forces NORMAL.
- NORMAL outputs: INC_S = en1hz; INC_M = CA_S; INC_H = CA_M.
- All combinational outputs are gated by registered state only, so there are no combinational loops.
- SET_H: INC_H = up_r. INC_S and INC_M are held 0, so the clock is frozen.
- SET_M: INC_M = up_r. INC_H is held 0; a minutes wrap during set does not carry into hours.
- SET_S: CLR_S = up_r, which zeroes the seconds stage. INC_* are held 0.
- up_r = up_p OR repeat pulse. Repeat pulse:
  - A hold counter counts en2hz ticks while the synchronized UP level is high, saturating at REP_DLY.
  - The counter clears when UP is low.
  - Once saturated, every en2hz while UP is held produces a repeat pulse.
  - Repeat is active only in SET_* states.
- Timeout counter (width clog2(TIMEOUT_S+1)):
  - Clears on mode_p, on up_p, and on entry to any SET_* state.
  - Increments on en1hz while in SET_*.
  - Held 0 in NORMAL.
- Blink phase: a flag that toggles on every en2hz and is forced 0 in NORMAL.
- BLANK_x = (state == SET_x) AND phase.
- Simultaneous events:
  - mode_p and up_p in the same cycle: mode_p wins. The state advances and no step strobe is emitted.
  - Timeout and mode_p in the same cycle: the state goes to NORMAL.
  - mode_p in NORMAL together with en1hz: that cycle's INC_S is still issued, because outputs are decoded from the current state.

## Timing
- Reset (RST low, asynchronous):
  - State NORMAL; synchronizers, edge registers, hold counter, timeout counter and phase all 0.
  - All outputs 0, except INC_S, INC_M and INC_H, which follow en1hz / CA_S / CA_M combinationally per NORMAL decode.
  - Reset deassertion mid-press: the synchronizer starts from 0, so a button already held high produces one edge pulse 3 cycles after release of RST.
- Button latency: raw edge to mode_p/up_p is 3 CLK cycles (2 sync + 1 edge register). The state changes on the following edge.
- Step strobes are combinational from state and pulse: INC_x coincides with up_r, 1 cycle wide.
- CA_S and CA_M pass through to INC_M and INC_H in the same cycle, zero latency. 59:59 + en1hz therefore advances all three stages on one clock edge.

## Structure
- Package clock_pkg:
  - state enum (NORMAL, SET_H, SET_M, SET_S), 2 bits;
  - default REP_DLY and TIMEOUT_S constants.
- Sub-module btn_edge (CLK, RST, raw, level, pulse) covers the synchronizer and rising-edge detector. It is instantiated twice; its level output feeds the hold counter for UP.
- The FSM, hold counter, timeout counter and blink phase stay in clock_set_ctrl.

## Test plan
- Reset behaviour: RST low mid-sequence -> state NORMAL, SETTING=0, BLANK_*=0 immediately; CLR_S=0.
- NORMAL carry chain: drive en1hz with CA_S=1, CA_M=1 -> INC_S, INC_M and INC_H all high in the same cycle. With CA_S=0 -> only INC_S.
- Mode cycle: 4 separate MODE presses -> SET_H, SET_M, SET_S, NORMAL, each state change 4 cycles after the raw edge. SETTING toggles accordingly. BLANK_H toggles on each en2hz in SET_H only.
- Set stepping: in SET_M, one UP press -> exactly one INC_M pulse. With CA_M forced 1 -> INC_H stays 0. In SET_S, UP -> one CLR_S pulse and no INC_S despite en1hz.
- Auto-repeat: UP held for 5 en2hz ticks in SET_H with REP_DLY=2 -> 1 edge pulse plus 3 repeat INC_H pulses. Same-cycle MODE+UP -> state advances with no INC strobe.
- Timeout: enter SET_H, then 30 en1hz ticks with no press -> NORMAL on the 30th tick. With an UP press at tick 20 -> still in SET_H at tick 30, NORMAL at tick 50.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and defaults for the hh:mm:ss mode/set controller.
//   state_t       : controller mode (NORMAL, SET_H, SET_M, SET_S)
//   DEF_REP_DLY   : default en2hz ticks UP must be held before auto-repeat
//   DEF_TIMEOUT_S : default en1hz ticks of inactivity before leaving set mode
package clock_pkg;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        SET_H  = 2'd1,
        SET_M  = 2'd2,
        SET_S  = 2'd3
    } state_t;

    localparam int DEF_REP_DLY   = 2;
    localparam int DEF_TIMEOUT_S = 30;

    // Successor of a state when the MODE button is pressed.
    function automatic state_t mode_next(input state_t s);
        case (s)
            NORMAL:  mode_next = SET_H;
            SET_H:   mode_next = SET_M;
            SET_M:   mode_next = SET_S;
            default: mode_next = NORMAL;
        endcase
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Button conditioner: 2-flop synchronizer followed by a registered
// rising-edge detector.
//   CLK   : system clock
//   RST   : asynchronous active-low reset
//   raw   : raw button level, asynchronous to CLK
//   level : synchronized button level
//   pulse : one-cycle pulse, 3 cycles after the raw rising edge
module btn_edge (
    input  logic CLK,
    input  logic RST,
    input  logic raw,
    output logic level,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            prev  <= sync2;
            pulse <= sync2 & ~prev;
        end
    end

    assign level = sync2;

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode/set controller for the hh:mm:ss counter stages.
// In NORMAL the seconds stage steps on en1hz and carries ripple through to
// minutes and hours. In SET_H/SET_M/SET_S the UP button steps (or, for
// seconds, clears) the selected stage, with auto-repeat, a blinking display
// mask and an inactivity timeout back to NORMAL.
//   CLK, RST            : clock, asynchronous active-low reset
//   en1hz, en2hz        : one-cycle prescaler strobes
//   BTN_MODE, BTN_UP    : raw active-high buttons
//   CA_S, CA_M          : carries of the seconds / minutes stages
//   INC_S, INC_M, INC_H : one-cycle step strobes to the stages
//   CLR_S               : synchronous clear of the seconds stage
//   SETTING             : high whenever not in NORMAL
//   BLANK_S/M/H         : display blank masks
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int REP_DLY   = DEF_REP_DLY,
    parameter int TIMEOUT_S = DEF_TIMEOUT_S
) (
    input  logic CLK,
    input  logic RST,
    input  logic en1hz,
    input  logic en2hz,
    input  logic BTN_MODE,
    input  logic BTN_UP,
    input  logic CA_S,
    input  logic CA_M,
    output logic INC_S,
    output logic INC_M,
    output logic INC_H,
    output logic CLR_S,
    output logic SETTING,
    output logic BLANK_S,
    output logic BLANK_M,
    output logic BLANK_H
);

    localparam int HW = (REP_DLY < 1) ? 1 : $clog2(REP_DLY + 1);
    localparam int TW = (TIMEOUT_S < 1) ? 1 : $clog2(TIMEOUT_S + 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(REP_DLY);
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_S - 1);

    state_t        state;
    state_t        state_nx;
    logic [HW-1:0] hold;
    logic [TW-1:0] tcnt;
    logic          phase;

    logic mode_p;
    logic mode_level_unused;
    logic up_p;
    logic up_level;

    logic setting;
    logic rep_p;
    logic up_r;
    logic step;
    logic expire;

    btn_edge u_mode (
        .CLK   (CLK),
        .RST   (RST),
        .raw   (BTN_MODE),
        .level (mode_level_unused),
        .pulse (mode_p)
    );

    btn_edge u_up (
        .CLK   (CLK),
        .RST   (RST),
        .raw   (BTN_UP),
        .level (up_level),
        .pulse (up_p)
    );

    assign setting = (state != NORMAL);

    // Auto-repeat fires on every en2hz once the hold counter has saturated.
    assign rep_p = setting & up_level & en2hz & (hold == HOLD_MAX);
    assign up_r  = up_p | rep_p;
    // A MODE pulse in the same cycle suppresses any step.
    assign step  = up_r & ~mode_p;

    // Expire on the en1hz that would bring the counter to TIMEOUT_S, so the
    // state is NORMAL right after that tick.
    assign expire = setting & en1hz & (tcnt >= TCNT_LAST);

    always_comb begin
        state_nx = state;
        if (mode_p) begin
            state_nx = mode_next(state);
        end
        if (expire) begin
            state_nx = NORMAL;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= NORMAL;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hold <= '0;
        end else if (!up_level) begin
            hold <= '0;
        end else if (en2hz && (hold != HOLD_MAX)) begin
            hold <= hold + 1'b1;
        end
    end

    // Any state change (entry into a SET state or leaving one) restarts it.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tcnt <= '0;
        end else if (!setting || mode_p || up_p || (state_nx != state)) begin
            tcnt <= '0;
        end else if (en1hz) begin
            tcnt <= tcnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            phase <= 1'b0;
        end else if (!setting) begin
            phase <= 1'b0;
        end else if (en2hz) begin
            phase <= ~phase;
        end
    end

    always_comb begin
        INC_S = 1'b0;
        INC_M = 1'b0;
        INC_H = 1'b0;
        CLR_S = 1'b0;
        case (state)
            NORMAL: begin
                INC_S = en1hz;
                INC_M = CA_S;
                INC_H = CA_M;
            end
            SET_H:   INC_H = step;
            SET_M:   INC_M = step;
            SET_S:   CLR_S = step;
            default: ;
        endcase
    end

    assign SETTING = setting;
    assign BLANK_H = (state == SET_H) & phase;
    assign BLANK_M = (state == SET_M) & phase;
    assign BLANK_S = (state == SET_S) & phase;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with hand-computed expectations.
module tb_clock_set_ctrl;
    import clock_pkg::*;

    logic CLK      = 1'b0;
    logic RST      = 1'b0;
    logic en1hz    = 1'b0;
    logic en2hz    = 1'b0;
    logic BTN_MODE = 1'b0;
    logic BTN_UP   = 1'b0;
    logic CA_S     = 1'b0;
    logic CA_M     = 1'b0;
    logic INC_S, INC_M, INC_H, CLR_S, SETTING, BLANK_S, BLANK_M, BLANK_H;

    int n_chk  = 0;
    int n_pass = 0;
    int cnt_s, cnt_m, cnt_h, cnt_clr, first_step;

    clock_set_ctrl #(.REP_DLY(2), .TIMEOUT_S(30)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .en1hz    (en1hz),
        .en2hz    (en2hz),
        .BTN_MODE (BTN_MODE),
        .BTN_UP   (BTN_UP),
        .CA_S     (CA_S),
        .CA_M     (CA_M),
        .INC_S    (INC_S),
        .INC_M    (INC_M),
        .INC_H    (INC_H),
        .CLR_S    (CLR_S),
        .SETTING  (SETTING),
        .BLANK_S  (BLANK_S),
        .BLANK_M  (BLANK_M),
        .BLANK_H  (BLANK_H)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic press_mode(input string tag, input state_t from, input state_t to);
        BTN_MODE = 1'b1;
        cyc(3);
        check_eq({tag, "_before"}, 32'(dut.state), 32'(from));
        cyc(1);
        check_eq({tag, "_after"}, 32'(dut.state), 32'(to));
        check_eq({tag, "_setting"}, 32'(SETTING), 32'(to != NORMAL));
        BTN_MODE = 1'b0;
        cyc(4);
    endtask

    // Hold UP for cycles 1..rel-1 and tally strobes over n cycles.
    task automatic up_window(input int n, input int rel, input logic e1, input logic [31:0] e2mask);
        cnt_s = 0; cnt_m = 0; cnt_h = 0; cnt_clr = 0; first_step = -1;
        BTN_UP = 1'b1;
        for (int i = 1; i <= n; i++) begin
            cyc(1);
            BTN_UP = (i < rel);
            en1hz  = e1;
            en2hz  = e2mask[i];
            #1;
            cnt_s   += int'(INC_S);
            cnt_m   += int'(INC_M);
            cnt_h   += int'(INC_H);
            cnt_clr += int'(CLR_S);
            if (first_step < 0 && (INC_M || INC_H || CLR_S)) first_step = i;
        end
        en1hz = 1'b0;
        en2hz = 1'b0;
        BTN_UP = 1'b0;
        cyc(4);
    endtask

    task automatic tick1;
        en1hz = 1'b1;
        cyc(1);
        en1hz = 1'b0;
        cyc(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state with NORMAL pass-through decode
        en1hz = 1'b1; CA_S = 1'b1; CA_M = 1'b0;
        #12;
        check_eq("rst_setting", 32'(SETTING), 32'd0);
        check_eq("rst_clr_s",   32'(CLR_S),   32'd0);
        check_eq("rst_blank",   32'({BLANK_H, BLANK_M, BLANK_S}), 32'd0);
        check_eq("rst_inc_s",   32'(INC_S),   32'd1);
        check_eq("rst_inc_m",   32'(INC_M),   32'd1);
        check_eq("rst_inc_h",   32'(INC_H),   32'd0);
        en1hz = 1'b0; CA_S = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1;
        cyc(2);

        // NORMAL carry chain
        en1hz = 1'b1; CA_S = 1'b1; CA_M = 1'b1; #1;
        check_eq("carry_all", 32'({INC_S, INC_M, INC_H}), 32'b111);
        CA_S = 1'b0; CA_M = 1'b0; #1;
        check_eq("carry_none", 32'({INC_S, INC_M, INC_H}), 32'b100);
        en1hz = 1'b0;
        cyc(1);

        // Enter SET_H, blink
        press_mode("m1", NORMAL, SET_H);
        check_eq("blink0", 32'({BLANK_H, BLANK_M, BLANK_S}), 32'b000);
        en2hz = 1'b1; cyc(1); en2hz = 1'b0; #1;
        check_eq("blink1", 32'({BLANK_H, BLANK_M, BLANK_S}), 32'b100);
        en2hz = 1'b1; cyc(1); en2hz = 1'b0; #1;
        check_eq("blink2", 32'({BLANK_H, BLANK_M, BLANK_S}), 32'b000);

        // Single UP in SET_H
        up_window(10, 5, 1'b0, 32'd0);
        check_eq("seth_inc_h", 32'(cnt_h), 32'd1);
        check_eq("seth_first", 32'(first_step), 32'd3);
        check_eq("seth_inc_sm", 32'(cnt_s + cnt_m), 32'd0);

        // SET_M: one INC_M, no carry into hours
        press_mode("m2", SET_H, SET_M);
        CA_M = 1'b1;
        up_window(10, 5, 1'b0, 32'd0);
        CA_M = 1'b0;
        check_eq("setm_inc_m", 32'(cnt_m), 32'd1);
        check_eq("setm_inc_h", 32'(cnt_h), 32'd0);
        check_eq("setm_inc_s", 32'(cnt_s), 32'd0);

        // SET_S: UP clears seconds, en1hz frozen
        press_mode("m3", SET_M, SET_S);
        up_window(10, 5, 1'b1, 32'd0);
        check_eq("sets_clr", 32'(cnt_clr), 32'd1);
        check_eq("sets_inc_s", 32'(cnt_s), 32'd0);
        check_eq("sets_inc_mh", 32'(cnt_m + cnt_h), 32'd0);

        press_mode("m4", SET_S, NORMAL);

        // MODE in NORMAL coinciding with en1hz still issues INC_S
        BTN_MODE = 1'b1;
        cyc(3);
        en1hz = 1'b1; #1;
        check_eq("modetick_inc_s", 32'(INC_S), 32'd1);
        check_eq("modetick_state", 32'(dut.state), 32'(NORMAL));
        cyc(1);
        en1hz = 1'b0;
        check_eq("modetick_next", 32'(dut.state), 32'(SET_H));
        BTN_MODE = 1'b0;
        cyc(4);

        // Auto-repeat: edge + 3 repeats over 5 en2hz ticks
        up_window(24, 20, 1'b0, (32'd1 << 6) | (32'd1 << 9) | (32'd1 << 12) | (32'd1 << 15) | (32'd1 << 18));
        check_eq("rep_inc_h", 32'(cnt_h), 32'd4);
        check_eq("rep_first", 32'(first_step), 32'd3);

        // MODE and UP together: advance, no step
        BTN_MODE = 1'b1; BTN_UP = 1'b1;
        cyc(3);
        check_eq("mu_inc", 32'({INC_S, INC_M, INC_H, CLR_S}), 32'd0);
        cyc(1);
        check_eq("mu_state", 32'(dut.state), 32'(SET_M));
        check_eq("mu_inc_after", 32'({INC_S, INC_M, INC_H, CLR_S}), 32'd0);
        BTN_MODE = 1'b0; BTN_UP = 1'b0;
        cyc(4);
        press_mode("m5", SET_M, SET_S);
        press_mode("m6", SET_S, NORMAL);

        // Timeout after 30 idle ticks
        press_mode("m7", NORMAL, SET_H);
        repeat (29) tick1();
        check_eq("to_29", 32'(SETTING), 32'd1);
        tick1();
        check_eq("to_30", 32'(SETTING), 32'd0);
        check_eq("to_30_state", 32'(dut.state), 32'(NORMAL));

        // UP at tick 20 restarts the timeout
        press_mode("m8", NORMAL, SET_H);
        repeat (20) tick1();
        BTN_UP = 1'b1; cyc(5); BTN_UP = 1'b0; cyc(4);
        repeat (10) tick1();
        check_eq("tou_30", 32'(SETTING), 32'd1);
        repeat (19) tick1();
        check_eq("tou_49", 32'(SETTING), 32'd1);
        tick1();
        check_eq("tou_50", 32'(SETTING), 32'd0);

        // Asynchronous reset mid-sequence, button held through release
        press_mode("m9", NORMAL, SET_H);
        en2hz = 1'b1; cyc(1); en2hz = 1'b0; #1;
        check_eq("pre_rst_blank", 32'(BLANK_H), 32'd1);
        BTN_MODE = 1'b1;
        #2;
        RST = 1'b0;
        #1;
        check_eq("arst_setting", 32'(SETTING), 32'd0);
        check_eq("arst_blank", 32'({BLANK_H, BLANK_M, BLANK_S}), 32'd0);
        check_eq("arst_clr_s", 32'(CLR_S), 32'd0);
        check_eq("arst_state", 32'(dut.state), 32'(NORMAL));
        cyc(2);
        RST = 1'b1;
        cyc(3);
        check_eq("rel_before", 32'(SETTING), 32'd0);
        cyc(1);
        check_eq("rel_after", 32'(dut.state), 32'(SET_H));
        BTN_MODE = 1'b0;
        cyc(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
